zone_dimming_ctrl: RTL and testbench
====================================

// Module: zone_dimming_ctrl
// PURPOSE
// - Local-dimming zone analyser between the gray/pixel-coordinate stage and MiniLED_driver.
// - Reduces each 1280x800 frame of data_gray to 9 zone levels (3x3 grid, 8 bit each), temporally smoothed.
// - Output word drives MiniLED_driver I_led_light directly; it changes only at frame commit.
// PARAMETERS
// - ZONE_W       427  zone width in pixels; x boundaries at ZONE_W and 2*ZONE_W
// - ZONE_H       267  zone height in lines; y boundaries at ZONE_H and 2*ZONE_H
// - MEAN_SHIFT   17   mean approximation: mean = sat255(sum >> MEAN_SHIFT)
// - ALPHA_SHIFT  2    IIR step shift; 0 = no smoothing, output = target
// - MIN_LEVEL    8'd0 floor applied to every committed zone level
// - VS_POL       1    active level of vsync
// PORTS
// - i_pix_clk          in   1   pixel clock, the only clock
// - rst_n              in   1   asynchronous active-low reset
// - data_de            in   1   pixel valid
// - vsync              in   1   frame sync, active level VS_POL
// - pix_x              in   11  pixel column, valid when data_de
// - pix_y              in   11  pixel row, valid when data_de
// - data_gray          in   8   pixel luminance
// - led_light_flatted  out  72  zone z level at [8z+7:8z], z = 3*zy + zx
// - frame_done         out  1   1-cycle pulse on commit
// - overrun            out  1   sticky; set when data_de is high outside IDLE; cleared only by reset
// BEHAVIOUR
// - Reset: all accumulators 0; state IDLE; led_light_flatted = {9{MIN_LEVEL}}; frame_done = 0; overrun = 0.
// - Zone map: zx = 0 if x<ZONE_W, 1 if x<2*ZONE_W, else 2. zy likewise with ZONE_H. Out-of-range coords clamp to zone 2.
// - Stage 1 (1 cycle): register de, gray, zone index.
// - Stage 2 (1 cycle): if de, max[z] <= max(max[z], gray) and sum[z] <= sum[z] + gray. sum[z] is 24 bit and saturates at 2^24-1.
// - Frame end: first cycle vsync == VS_POL while the previous sample != VS_POL (edge; level is ignored).
// - FSM:
//   - IDLE: on frame end, go to DRAIN.
//   - DRAIN (1 cycle): lets the stage-2 write retire, then UPDATE.
//   - UPDATE (9 cycles, z = 0..8): build the new level for zone z in a shadow register.
//     - mean = min(255, sum[z] >> MEAN_SHIFT); target = (max[z] + mean) >> 1 (9-bit add, result 8 bit).
//     - d = target - cur[z] (signed 9 bit); step = d >>> ALPHA_SHIFT.
//     - If d != 0 and step == 0, step = sign(d)*1, so the level always converges to target.
//     - new = cur[z] + step, then clamp to >= MIN_LEVEL.
//     - Clear max[z] and sum[z] in the same cycle.
//   - COMMIT (1 cycle): copy the shadow to led_light_flatted atomically; pulse frame_done; return to IDLE.
// - Latency: frame-end edge sampled at cycle 0 -> DRAIN at 1, UPDATE at 2..10, COMMIT at 11; new output and frame_done visible at cycle 12.
// - Pixels with de during DRAIN/UPDATE/COMMIT are dropped and set overrun.
// - A frame-end edge outside IDLE is ignored; no frame_done is produced for it.
// - Accumulation restarts in IDLE; pixels from the previous frame never leak into the next frame.
// - Reset mid-UPDATE: output returns to {9{MIN_LEVEL}} and the partial shadow is discarded.
// - Between commits led_light_flatted is static; the consumer in the I_clk domain double-samples it after frame_done.
// TESTING
// - Reset, then hold with no stimulus -> led_light_flatted = 72'h0, frame_done = 0, overrun = 0.
// - ALPHA_SHIFT=0: black frame, single pixel 255 at (1000,700), vsync edge
//   -> zone 8 = 127 (max 255, mean 0), zones 0-7 = 0; frame_done exactly 12 cycles after the edge.
// - ALPHA_SHIFT=0: full frame gray 200 -> zone 0 (427x267 pixels) = (200 + 173) >> 1 = 186.
// - ALPHA_SHIFT=2: repeat the single-pixel frame -> zone 8 = 31, then 55, then 73, ...; reaches 127 with a final +/-1 step, never overshoots.
// - Assert data_de during UPDATE -> overrun latches 1; committed levels unaffected by those pixels.
// - MIN_LEVEL=16: black frame -> every zone = 16.
// - Pull rst_n low at UPDATE z=4 -> output = {9{MIN_LEVEL}}; no frame_done pulse.

Source files
------------

// File: rtl/zone_dimming_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : zone_dimming_ctrl
//  Purpose  : Local-dimming zone analyser. Reduces each frame of gray pixels
//             to a 3x3 grid of temporally smoothed 8-bit zone levels that
//             drive the MiniLED driver directly. Output changes only at the
//             frame commit.
//  Revision : 1.0  initial release
// ============================================================================
module zone_dimming_ctrl #(
  parameter int         ZONE_W      = 427,
  parameter int         ZONE_H      = 267,
  parameter int         MEAN_SHIFT  = 17,
  parameter int         ALPHA_SHIFT = 2,
  parameter logic [7:0] MIN_LEVEL   = 8'd0,
  parameter logic       VS_POL      = 1'b1
) (
  input  logic        i_pix_clk,
  input  logic        rst_n,
  input  logic        data_de,
  input  logic        vsync,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic [7:0]  data_gray,
  output logic [71:0] led_light_flatted,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_UPDATE = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  zidx_q, zidx_d;
  logic        de1_q, de1_d;
  logic [7:0]  gray1_q, gray1_d;
  logic [3:0]  zone1_q, zone1_d;
  logic [23:0] sum_q [9];
  logic [23:0] sum_d [9];
  logic [7:0]  max_q [9];
  logic [7:0]  max_d [9];
  logic [7:0]  shadow_q [9];
  logic [7:0]  shadow_d [9];
  logic [7:0]  level_q [9];
  logic [7:0]  level_d [9];
  logic        frame_done_q, frame_done_d;
  logic        overrun_q, overrun_d;
  logic        vs_prev_q, vs_prev_d;

  logic              frame_end_w;
  logic [1:0]        zx_w, zy_w;
  logic [23:0]       mean_full_w;
  logic [7:0]        mean_w, target_w, cur_w, new_w;
  logic [8:0]        tsum_w;
  logic signed [8:0] d_w, step_w;
  logic signed [9:0] new_ext_w;

  function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [7:0] b);
    logic [24:0] s;
    s = {1'b0, a} + {17'd0, b};
    return s[24] ? 24'hFF_FFFF : s[23:0];
  endfunction

  // Pixel zone lookup, stage-1 capture, frame-end edge and sticky overrun.
  always_comb begin
    zx_w = (pix_x < 11'(ZONE_W)) ? 2'd0 : (pix_x < 11'(2 * ZONE_W)) ? 2'd1 : 2'd2;
    zy_w = (pix_y < 11'(ZONE_H)) ? 2'd0 : (pix_y < 11'(2 * ZONE_H)) ? 2'd1 : 2'd2;
    zone1_d     = {2'b00, zy_w} + {1'b0, zy_w, 1'b0} + {2'b00, zx_w};
    gray1_d     = data_gray;
    // Only pixels arriving in IDLE enter the pipeline; the rest are dropped.
    de1_d       = data_de & (state_q == S_IDLE);
    overrun_d   = overrun_q | (data_de & (state_q != S_IDLE));
    vs_prev_d   = vsync;
    frame_end_w = (vsync == VS_POL) && (vs_prev_q != VS_POL);
  end

  // Stage-2 max/sum accumulation; a zone is cleared while it is being updated.
  always_comb begin
    sum_d = sum_q;
    max_d = max_q;
    for (int z = 0; z < 9; z++) begin
      if (de1_q && (zone1_q == 4'(z))) begin
        if (gray1_q > max_q[z]) max_d[z] = gray1_q;
        sum_d[z] = sat_add(sum_q[z], gray1_q);
      end
      if ((state_q == S_UPDATE) && (zidx_q == 4'(z))) begin
        sum_d[z] = '0;
        max_d[z] = '0;
      end
    end
  end

  // New level for the zone addressed by zidx: IIR step toward (max+mean)/2.
  always_comb begin
    cur_w       = level_q[zidx_q];
    mean_full_w = sum_q[zidx_q] >> MEAN_SHIFT;
    mean_w      = (mean_full_w > 24'd255) ? 8'hFF : mean_full_w[7:0];
    tsum_w      = {1'b0, max_q[zidx_q]} + {1'b0, mean_w};
    target_w    = 8'(tsum_w >> 1);
    d_w         = $signed({1'b0, target_w}) - $signed({1'b0, cur_w});
    step_w      = d_w >>> ALPHA_SHIFT;
    // Small positive differences shift to zero; force a unit step so the
    // level always reaches the target exactly.
    if ((d_w != 9'sd0) && (step_w == 9'sd0)) step_w = d_w[8] ? -9'sd1 : 9'sd1;
    new_ext_w   = $signed({2'b00, cur_w}) + $signed({step_w[8], step_w});
    new_w       = (new_ext_w < $signed({2'b00, MIN_LEVEL})) ? MIN_LEVEL : new_ext_w[7:0];
  end

  // Frame FSM: next state, zone index, shadow build and atomic commit.
  always_comb begin
    state_d      = state_q;
    zidx_d       = zidx_q;
    shadow_d     = shadow_q;
    level_d      = level_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_end_w) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_UPDATE;
        zidx_d  = 4'd0;
      end
      S_UPDATE: begin
        shadow_d[zidx_q] = new_w;
        if (zidx_q == 4'd8) state_d = S_COMMIT;
        else                zidx_d  = zidx_q + 4'd1;
      end
      S_COMMIT: begin
        level_d      = shadow_q;
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      zidx_q       <= 4'd0;
      de1_q        <= 1'b0;
      gray1_q      <= 8'd0;
      zone1_q      <= 4'd0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      vs_prev_q    <= VS_POL;
      for (int z = 0; z < 9; z++) begin
        sum_q[z]    <= '0;
        max_q[z]    <= '0;
        shadow_q[z] <= MIN_LEVEL;
        level_q[z]  <= MIN_LEVEL;
      end
    end else begin
      state_q      <= state_d;
      zidx_q       <= zidx_d;
      de1_q        <= de1_d;
      gray1_q      <= gray1_d;
      zone1_q      <= zone1_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      vs_prev_q    <= vs_prev_d;
      sum_q        <= sum_d;
      max_q        <= max_d;
      shadow_q     <= shadow_d;
      level_q      <= level_d;
    end
  end

  generate
    for (genvar gz = 0; gz < 9; gz++) begin : g_pack
      assign led_light_flatted[8*gz +: 8] = level_q[gz];
    end
  endgenerate

  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_zone_dimming_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zone_dimming_ctrl
//  Purpose  : Self-checking bench for zone_dimming_ctrl. Three instances share
//             the stimulus: ALPHA_SHIFT=0, ALPHA_SHIFT=2, and ALPHA_SHIFT=0
//             with MIN_LEVEL=16. Expected words are queued at each frame end
//             and compared when frame_done fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zone_dimming_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, data_de, vsync;
  logic [10:0] px, py;
  logic [7:0]  gray;
  logic [71:0] led_a0, led_a2, led_m16;
  logic        fd_a0, fd_a2, fd_m16;
  logic        ov_a0, ov_a2, ov_m16;

  int n_assert = 0;
  int n_fail   = 0;

  int cur  [3][9];
  int msum [9];
  int mmax [9];
  int alpha [3] = '{0, 2, 0};
  int minl  [3] = '{0, 0, 16};
  logic [71:0] q0 [$];
  logic [71:0] q1 [$];
  logic [71:0] q2 [$];

  always #5 clk = ~clk;

  zone_dimming_ctrl #(.ALPHA_SHIFT(0)) u_a0 (
    .i_pix_clk(clk), .rst_n(rst_n), .data_de(data_de), .vsync(vsync),
    .pix_x(px), .pix_y(py), .data_gray(gray),
    .led_light_flatted(led_a0), .frame_done(fd_a0), .overrun(ov_a0));

  zone_dimming_ctrl #(.ALPHA_SHIFT(2)) u_a2 (
    .i_pix_clk(clk), .rst_n(rst_n), .data_de(data_de), .vsync(vsync),
    .pix_x(px), .pix_y(py), .data_gray(gray),
    .led_light_flatted(led_a2), .frame_done(fd_a2), .overrun(ov_a2));

  zone_dimming_ctrl #(.ALPHA_SHIFT(0), .MIN_LEVEL(8'd16)) u_m16 (
    .i_pix_clk(clk), .rst_n(rst_n), .data_de(data_de), .vsync(vsync),
    .pix_x(px), .pix_y(py), .data_gray(gray),
    .led_light_flatted(led_m16), .frame_done(fd_m16), .overrun(ov_m16));

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int zone_of(input int x, input int y);
    int zx, zy;
    zx = (x < 427) ? 0 : (x < 854) ? 1 : 2;
    zy = (y < 267) ? 0 : (y < 534) ? 1 : 2;
    return 3 * zy + zx;
  endfunction

  // Reference IIR for one instance: updates cur[k] and returns the packed word.
  task automatic model_frame(input int k, output logic [71:0] w);
    int mean, target, d, step, nv, a;
    a = alpha[k];
    for (int z = 0; z < 9; z++) begin
      mean   = msum[z] / (1 << 17);
      if (mean > 255) mean = 255;
      target = (mmax[z] + mean) / 2;
      d      = target - cur[k][z];
      if (d >= 0) step = d / (1 << a);
      else        step = -((-d + (1 << a) - 1) / (1 << a));
      if (d != 0 && step == 0) step = (d > 0) ? 1 : -1;
      nv = cur[k][z] + step;
      if (nv < minl[k]) nv = minl[k];
      cur[k][z] = nv;
      w[8*z +: 8] = 8'(nv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int z = 0; z < 9; z++) cur[k][z] = minl[k];
    for (int z = 0; z < 9; z++) begin
      msum[z] = 0;
      mmax[z] = 0;
    end
  endtask

  task automatic send_pix(input int x, input int y, input int g);
    int z;
    @(negedge clk);
    data_de = 1'b1;
    px = 11'(x);
    py = 11'(y);
    gray = 8'(g);
    z = zone_of(x, y);
    if (g > mmax[z]) mmax[z] = g;
    msum[z] = msum[z] + g;
    if (msum[z] > 16777215) msum[z] = 16777215;
  endtask

  // Queue expectations, pulse vsync, measure frame_done latency. With inject,
  // a pixel and a second vsync edge are driven while the FSM is in UPDATE.
  task automatic frame_end(input bit inject);
    logic [71:0] w;
    int lat;
    model_frame(0, w); q0.push_back(w);
    model_frame(1, w); q1.push_back(w);
    model_frame(2, w); q2.push_back(w);
    for (int z = 0; z < 9; z++) begin
      msum[z] = 0;
      mmax[z] = 0;
    end
    @(negedge clk);
    data_de = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    lat = 99;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (inject && n == 3) begin
        data_de = 1'b1; px = 11'd10; py = 11'd10; gray = 8'd255; vsync = 1'b1;
      end else if (inject && n == 4) begin
        data_de = 1'b0; vsync = 1'b0;
      end
      if (fd_a0) begin
        lat = n;
        break;
      end
    end
    chk("done_latency", 72'(lat), 72'd11);
    @(negedge clk);
  endtask

  // Scoreboard: every frame_done must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fd_a0) begin
        chk("a0_spurious_done", 72'(q0.size() == 0), 72'd0);
        if (q0.size() != 0) chk("a0_level", led_a0, q0.pop_front());
      end
      if (fd_a2) begin
        chk("a2_spurious_done", 72'(q1.size() == 0), 72'd0);
        if (q1.size() != 0) chk("a2_level", led_a2, q1.pop_front());
      end
      if (fd_m16) begin
        chk("m16_spurious_done", 72'(q2.size() == 0), 72'd0);
        if (q2.size() != 0) chk("m16_level", led_m16, q2.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fd_cnt;
    rst_n = 1'b0; data_de = 1'b0; vsync = 1'b0;
    px = '0; py = '0; gray = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state.
    chk("rst_led_a0", led_a0, 72'h0);
    chk("rst_led_a2", led_a2, 72'h0);
    chk("rst_led_m16", led_m16, {9{8'd16}});
    chk("rst_done", 72'({fd_a0, fd_a2, fd_m16}), 72'd0);
    chk("rst_overrun", 72'({ov_a0, ov_a2, ov_m16}), 72'd0);

    // Single bright pixel in zone 8 on a black frame.
    send_pix(1000, 700, 255);
    frame_end(1'b0);
    chk("single_a0", led_a0, {8'd127, 64'd0});
    chk("single_m16", led_m16, {8'd127, {8{8'd16}}});
    chk("iir_a2_f1", 72'(led_a2[71:64]), 72'd31);
    send_pix(1000, 700, 255);
    frame_end(1'b0);
    chk("iir_a2_f2", 72'(led_a2[71:64]), 72'd55);
    send_pix(1000, 700, 255);
    frame_end(1'b0);
    chk("iir_a2_f3", 72'(led_a2[71:64]), 72'd73);
    for (int f = 0; f < 18; f++) begin
      send_pix(1000, 700, 255);
      frame_end(1'b0);
    end
    chk("iir_a2_converged", 72'(led_a2[71:64]), 72'd127);
    send_pix(1000, 700, 255);
    frame_end(1'b0);
    chk("iir_a2_no_overshoot", 72'(led_a2[71:64]), 72'd127);

    // Zone boundaries and out-of-range clamping.
    send_pix(426, 0, 40);
    send_pix(427, 0, 60);
    send_pix(853, 0, 80);
    send_pix(854, 0, 100);
    send_pix(2000, 266, 120);
    send_pix(0, 267, 140);
    send_pix(0, 534, 160);
    send_pix(0, 2047, 180);
    frame_end(1'b0);
    chk("boundary_a0", led_a0,
        {8'd0, 8'd0, 8'd90, 8'd0, 8'd0, 8'd70, 8'd60, 8'd40, 8'd20});

    // Mean contribution: 2048 pixels of 200 in zone 4.
    for (int i = 0; i < 2048; i++) send_pix(500 + (i % 64), 300 + (i / 64), 200);
    frame_end(1'b0);
    chk("mean_a0", led_a0, {32'd0, 8'd101, 32'd0});
    chk("mean_m16", led_m16, {{4{8'd16}}, 8'd101, {4{8'd16}}});

    // Pixels and a vsync edge during UPDATE are ignored and set overrun.
    send_pix(100, 100, 10);
    frame_end(1'b1);
    chk("overrun_levels_a0", led_a0, {64'd0, 8'd5});
    chk("overrun_flag", 72'({ov_a0, ov_a2, ov_m16}), 72'd7);
    repeat (20) @(negedge clk);

    // Reset while updating zone 4: outputs return to the floor, no commit.
    send_pix(1000, 700, 255);
    @(negedge clk);
    data_de = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_led_a0", led_a0, 72'h0);
    chk("midrst_led_m16", led_m16, {9{8'd16}});
    chk("midrst_overrun", 72'({ov_a0, ov_a2, ov_m16}), 72'd0);
    rst_n = 1'b1;
    model_reset();
    fd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fd_a0 || fd_a2 || fd_m16) fd_cnt++;
    end
    chk("midrst_no_done", 72'(fd_cnt), 72'd0);
    chk("midrst_led_hold_a2", led_a2, 72'h0);

    // Fresh frame after reset starts smoothing from zero again.
    send_pix(1000, 700, 255);
    frame_end(1'b0);
    chk("post_rst_a2", 72'(led_a2[71:64]), 72'd31);
    chk("post_rst_a0", led_a0, {8'd127, 64'd0});
    repeat (4) @(negedge clk);
    chk("queues_drained", 72'(q0.size() + q1.size() + q2.size()), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
